// File: rtl/gray_to_ex3_serial_if.sv
// Valid/ready handshake bundle between a Gray digit source, the decoder and
// an Excess-3 consumer.
interface gray_to_ex3_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] gray;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ex3;
  logic       out_err;

  modport slave (
    input  in_valid,
    input  gray,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ex3,
    output out_err
  );

  modport master (
    output in_valid,
    output gray,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ex3,
    input  out_err
  );
endinterface

// File: rtl/gray_to_ex3_serial.sv
// Bit-serial Gray-to-Excess-3 digit decoder: MSB-first Gray-to-binary
// resolution, then a registered +3 bias with optional decimal range check.
//
// state | meaning
// IDLE  | ready for a digit, gray captured on acceptance
// SHIFT | resolving one binary bit per clock, k = 3..0
// DONE  | registering ex3/out_err, bumping err_count
// HOLD  | result presented until out_ready
module gray_to_ex3_serial #(
  parameter bit CHECK_RANGE = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_to_ex3_serial_if.slave   bus,
  output logic [CNT_W-1:0]      err_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] g_reg;
  logic [3:0] bin_reg;
  logic [1:0] k;
  logic [3:0] ex3_reg;
  logic       err_reg;
  logic       prev_bit;
  logic [3:0] bin_plus3;
  logic       range_err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT: if (k == 2'd0)     state_nxt = DONE;
      DONE:                     state_nxt = HOLD;
      HOLD:  if (bus.out_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // The MSB has no higher neighbour, so it XORs against zero.
  always_comb begin
    prev_bit  = (k == 2'd3) ? 1'b0 : bin_reg[k + 2'd1];
    bin_plus3 = bin_reg + 4'd3;
    range_err = CHECK_RANGE && (bin_reg > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_reg     <= 4'd0;
      bin_reg   <= 4'd0;
      k         <= 2'd0;
      ex3_reg   <= 4'd0;
      err_reg   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            g_reg   <= bus.gray;
            bin_reg <= 4'd0;
            k       <= 2'd3;
          end
        end
        SHIFT: begin
          bin_reg[k] <= prev_bit ^ g_reg[k];
          k          <= k - 2'd1;
        end
        DONE: begin
          ex3_reg <= range_err ? 4'd0 : bin_plus3;
          err_reg <= range_err;
          if (range_err && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.ex3       = ex3_reg;
  assign bus.out_err   = err_reg;

endmodule

// File: tb/tb_gray_to_ex3_serial.sv
// Randomized bench for gray_to_ex3_serial: range-checked and pass-through
// instances driven in lockstep and compared with an arithmetic reference.
module tb_gray_to_ex3_serial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] gray;
  logic       out_ready;
  logic [7:0] err_count1;
  logic [7:0] err_count0;

  int total;
  int bad;
  int cnt1;
  int cnt0;

  gray_to_ex3_serial_if i1 ();
  gray_to_ex3_serial_if i0 ();

  assign i1.in_valid  = in_valid;
  assign i1.gray      = gray;
  assign i1.out_ready = out_ready;
  assign i0.in_valid  = in_valid;
  assign i0.gray      = gray;
  assign i0.out_ready = out_ready;

  gray_to_ex3_serial #(.CHECK_RANGE(1'b1), .CNT_W(8)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (i1),
    .err_count (err_count1)
  );

  gray_to_ex3_serial #(.CHECK_RANGE(1'b0), .CNT_W(8)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (i0),
    .err_count (err_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_bin(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic ref_err(input logic [3:0] g, input bit check);
    return check && (ref_bin(g) > 4'd9);
  endfunction

  function automatic logic [3:0] ref_ex3(input logic [3:0] g, input bit check);
    int b;
    b = int'(ref_bin(g));
    if (check && b > 9) return 4'd0;
    return 4'((b + 3) % 16);
  endfunction

  // Offers one digit, measures latency, optionally back-pressures, then
  // completes the output handshake. Called and returns at a negedge.
  task automatic run_digit(input logic [3:0] g, input int hold);
    int n;
    logic [3:0] e1, e0;
    logic r1;
    in_valid  = 1'b1;
    gray      = g;
    out_ready = 1'b0;
    n = 0;
    while (!i1.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 1);
    @(negedge clk);
    in_valid = 1'b0;
    gray     = 4'($urandom);
    chk("in_ready_drop", 32'(i1.in_ready), 0);
    n = 0;
    while (!i1.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 5);
    e1 = ref_ex3(g, 1'b1);
    e0 = ref_ex3(g, 1'b0);
    r1 = ref_err(g, 1'b1);
    if (r1 && cnt1 < 255) cnt1++;
    chk("ex3_chk", 32'(i1.ex3), 32'(e1));
    chk("err_chk", 32'(i1.out_err), 32'(r1));
    chk("cnt_chk", 32'(err_count1), cnt1);
    chk("valid_raw", 32'(i0.out_valid), 1);
    chk("ex3_raw", 32'(i0.ex3), 32'(e0));
    chk("err_raw", 32'(i0.out_err), 0);
    chk("cnt_raw", 32'(err_count0), cnt0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      gray     = 4'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(i1.out_valid), 1);
      chk("hold_ex3", 32'(i1.ex3), 32'(e1));
      chk("hold_in_ready", 32'(i1.in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", 32'(i1.out_valid), 0);
    chk("post_in_ready", 32'(i1.in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] g;
    total     = 0;
    bad       = 0;
    cnt1      = 0;
    cnt0      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    gray      = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(i1.in_ready), 1);
    chk("rst_out_valid", 32'(i1.out_valid), 0);
    chk("rst_ex3", 32'(i1.ex3), 0);
    chk("rst_err", 32'(i1.out_err), 0);
    chk("rst_cnt", 32'(err_count1), 0);

    run_digit(4'b0000, 0);
    run_digit(4'b1101, 0);
    run_digit(4'b0111, 0);
    run_digit(4'b1111, 0);
    run_digit(4'b0001, 10);

    // Reset during the second SHIFT cycle drops the digit.
    in_valid = 1'b1;
    gray     = 4'b0110;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    cnt1 = 0;
    cnt0 = 0;
    chk("midrst_in_ready", 32'(i1.in_ready), 1);
    chk("midrst_ex3", 32'(i1.ex3), 0);
    chk("midrst_cnt", 32'(err_count1), 0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i1.out_valid) n++;
    end
    chk("midrst_no_valid", n, 0);
    run_digit(4'b0011, 0);

    for (int i = 0; i < 10; i++) begin
      g = 4'(i ^ (i >> 1));
      run_digit(g, 0);
    end

    for (int i = 0; i < 40; i++)
      run_digit(4'($urandom), int'($urandom_range(0, 3)));

    for (int i = 0; i < 256; i++)
      run_digit(4'b1110, 0);
    chk("sat_final", 32'(err_count1), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
